// File: rtl/vnlp_pkg.sv
// Shared definitions for the VNLP linked-list node memory format.
package vnlp_pkg;

    localparam int ADDR_W = 9;
    localparam int WORD_W = 24;
    localparam int LEN_W  = 7;

    localparam logic [ADDR_W-1:0] HEAD_ADDR = 9'd0;
    localparam logic [ADDR_W-1:0] NULL_LINK = 9'd0;

    typedef enum logic [2:0] {
        WR_IDLE   = 3'd0,
        WR_HDR    = 3'd1,
        WR_ACCEPT = 3'd2,
        WR_DATA   = 3'd3,
        WR_TERM   = 3'd4,
        WR_LINK   = 3'd5,
        WR_FIN    = 3'd6
    } wr_state_t;

    // A link word is the 9-bit node address zero-extended to a full memory word.
    function automatic logic [WORD_W-1:0] link_word(input logic [ADDR_W-1:0] addr);
        return {15'd0, addr};
    endfunction

endpackage

// File: rtl/vnlp_list_writer_if.sv
// Element stream (valid/ready) plus node-memory write port of the list writer.
interface vnlp_list_writer_if;
    import vnlp_pkg::*;

    logic              elem_valid;
    logic [WORD_W-1:0] elem_data;
    logic              elem_last;
    logic              elem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    // Producer of elements / owner of the memory.
    modport master (
        output elem_valid, elem_data, elem_last,
        input  elem_ready, mem_we, mem_waddr, mem_wdata
    );

    // The list writer itself.
    modport slave (
        input  elem_valid, elem_data, elem_last,
        output elem_ready, mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/vnlp_list_writer.sv
// Writes an element stream into node memory as a singly linked list that is
// terminated after every completed element (data, terminator, then link).
module vnlp_list_writer
    import vnlp_pkg::*;
#(
    parameter int BASE    = 2,
    parameter int STRIDE  = 2,
    parameter int MAX_LEN = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              START,
    vnlp_list_writer_if.slave bus,
    output logic [LEN_W-1:0]  LEN,
    output logic              DONE,
    output logic              OVF
);

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);
    localparam logic [LEN_W-1:0]  LEN_LIMIT = LEN_W'(MAX_LEN - 1);

    if ((BASE + (MAX_LEN - 1) * STRIDE + 1 > 511) || (BASE == 0) || (BASE % 2 != 0) ||
        (STRIDE < 2) || (STRIDE % 2 != 0) || (MAX_LEN < 1) || (MAX_LEN > 127)) begin : g_param_check
        $error("vnlp_list_writer: node layout does not fit the 512-word memory");
    end

    wr_state_t         state_r;
    logic [ADDR_W-1:0] cur_r;
    logic [ADDR_W-1:0] prev_r;
    logic              last_r;
    logic [LEN_W-1:0]  len_r;
    logic              done_r;
    logic              ovf_r;
    logic              ready_r;
    logic              we_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [WORD_W-1:0] wdata_r;

    // Writer FSM: outputs are registered for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WR_IDLE;
            cur_r   <= 9'd0;
            prev_r  <= 9'd0;
            last_r  <= 1'b0;
            len_r   <= 7'd0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            ready_r <= 1'b0;
            we_r    <= 1'b0;
            waddr_r <= 9'd0;
            wdata_r <= 24'd0;
        end else begin
            case (state_r)
                WR_IDLE, WR_FIN: begin
                    if (START) begin
                        len_r   <= 7'd0;
                        done_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        cur_r   <= BASE_A;
                        prev_r  <= HEAD_ADDR;
                        we_r    <= 1'b1;
                        waddr_r <= HEAD_ADDR;
                        wdata_r <= link_word(NULL_LINK);
                        state_r <= WR_HDR;
                    end else begin
                        state_r <= state_r;
                    end
                end
                WR_HDR: begin
                    we_r    <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= WR_ACCEPT;
                end
                WR_ACCEPT: begin
                    if (bus.elem_valid && ready_r) begin
                        last_r  <= bus.elem_last;
                        ready_r <= 1'b0;
                        we_r    <= 1'b1;
                        waddr_r <= cur_r + 9'd1;
                        wdata_r <= bus.elem_data;
                        state_r <= WR_DATA;
                    end else begin
                        state_r <= WR_ACCEPT;
                    end
                end
                WR_DATA: begin
                    // Terminate the new tail before it becomes reachable.
                    waddr_r <= cur_r;
                    wdata_r <= link_word(NULL_LINK);
                    state_r <= WR_TERM;
                end
                WR_TERM: begin
                    // Link the predecessor (or the header) to the new tail.
                    waddr_r <= prev_r;
                    wdata_r <= link_word(cur_r);
                    state_r <= WR_LINK;
                end
                WR_LINK: begin
                    we_r   <= 1'b0;
                    len_r  <= len_r + 7'd1;
                    prev_r <= cur_r;
                    cur_r  <= cur_r + STRIDE_A;
                    if (last_r) begin
                        done_r  <= 1'b1;
                        state_r <= WR_FIN;
                    end else if (len_r == LEN_LIMIT) begin
                        done_r  <= 1'b1;
                        ovf_r   <= 1'b1;
                        state_r <= WR_FIN;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= WR_ACCEPT;
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    we_r    <= 1'b0;
                    state_r <= WR_IDLE;
                end
            endcase
        end
    end

    assign bus.elem_ready = ready_r;
    assign bus.mem_we     = we_r;
    assign bus.mem_waddr  = waddr_r;
    assign bus.mem_wdata  = wdata_r;
    assign LEN            = len_r;
    assign DONE           = done_r;
    assign OVF            = ovf_r;

endmodule

// File: tb/tb_vnlp_list_writer.sv
// Directed self-checking bench for vnlp_list_writer with a memory/reader model.
module tb_vnlp_list_writer;
    import vnlp_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       START;
    logic [6:0] LEN;
    logic       DONE;
    logic       OVF;

    int checks;
    int failures;
    int gap_writes;

    logic [23:0] mem [0:511];
    logic [32:0] wlog [$];

    vnlp_list_writer_if bus ();

    vnlp_list_writer #(.BASE(2), .STRIDE(2), .MAX_LEN(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .START (START),
        .bus   (bus.slave),
        .LEN   (LEN),
        .DONE  (DONE),
        .OVF   (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Node memory model plus write log and gap-write monitor.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_waddr] <= bus.mem_wdata;
            wlog.push_back({bus.mem_waddr, bus.mem_wdata});
            if (bus.elem_ready && !bus.elem_valid) gap_writes++;
        end
    end

    // Reference reader: walk from the header until a null link.
    task automatic read_list(output int n, output longint unsigned s);
        logic [8:0] p;
        longint unsigned w;
        n = 0;
        s = 0;
        p = mem[HEAD_ADDR][8:0];
        while (p != NULL_LINK && n < 200) begin
            w = 64'(mem[p + 9'd1]);
            s += w * w;
            n++;
            p = mem[p][8:0];
        end
    endtask

    // Pulse START for one cycle; returns at the negedge after it was sampled.
    task automatic start_list();
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
    endtask

    // Offer one element (from a negedge); returns at the negedge after the handshake.
    task automatic offer(input logic [23:0] d, input logic l, input int budget, output bit ok);
        bus.elem_valid = 1'b1;
        bus.elem_data  = d;
        bus.elem_last  = l;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (bus.elem_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (DONE) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        START = 1'b0;
        bus.elem_valid = 1'b0;
        bus.elem_data  = 24'd0;
        bus.elem_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({LEN, DONE, OVF, bus.elem_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== 44'd0) begin
            failures++;
            $display("FAIL reset_outputs: LEN=%0d DONE=%b OVF=%b rdy=%b we=%b addr=%0d data=%h, all required 0",
                     LEN, DONE, OVF, bus.elem_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata);
        end
    endtask

    task automatic test_basic_list(input int gap, input string tag);
        logic [32:0] exp_w [10] = '{{9'd0, 24'd0}, {9'd3, 24'd5}, {9'd2, 24'd0}, {9'd0, 24'd2},
                                   {9'd5, 24'd7}, {9'd4, 24'd0}, {9'd2, 24'd4},
                                   {9'd7, 24'hFFFFFF}, {9'd6, 24'd0}, {9'd4, 24'd6}};
        logic [23:0] vals [3] = '{24'd5, 24'd7, 24'hFFFFFF};
        bit ok;
        int n;
        longint unsigned s;
        longint unsigned exp_s;
        wlog.delete();
        gap_writes = 0;
        start_list();
        for (int i = 0; i < 3; i++) begin
            if (gap > 0 && i > 0) begin
                bus.elem_valid = 1'b0;
                for (int t = 0; t < 20 && !bus.elem_ready; t++) @(negedge clk);
                for (int g = 0; g < gap; g++) begin
                    checks++;
                    if (bus.elem_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL %s ready_in_gap: got %b, required 1", tag, bus.elem_ready);
                    end
                    @(negedge clk);
                end
            end
            offer(vals[i], (i == 2), 20, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s handshake%0d: no handshake within budget, required one", tag, i);
            end
        end
        bus.elem_valid = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || LEN !== 7'd3 || OVF !== 1'b0) begin
            failures++;
            $display("FAIL %s status: DONE=%b LEN=%0d OVF=%b, required DONE=1 LEN=3 OVF=0", tag, DONE, LEN, OVF);
        end
        checks++;
        if (wlog.size() != 10) begin
            failures++;
            $display("FAIL %s write_count: got %0d, required 10", tag, wlog.size());
        end
        for (int i = 0; i < 10 && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL %s write%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         tag, i, wlog[i][32:24], wlog[i][23:0], exp_w[i][32:24], exp_w[i][23:0]);
            end
        end
        checks++;
        if (gap_writes != 0) begin
            failures++;
            $display("FAIL %s gap_writes: got %0d, required 0", tag, gap_writes);
        end
        read_list(n, s);
        exp_s = 64'd25 + 64'd49 + 64'hFFFFFF * 64'hFFFFFF;
        checks++;
        if (n != 3 || s != exp_s) begin
            failures++;
            $display("FAIL %s reader: len=%0d sum=%0d, required len=3 sum=%0d", tag, n, s, exp_s);
        end
    endtask

    task automatic test_single();
        int c;
        int n;
        longint unsigned s;
        bus.elem_valid = 1'b1;
        bus.elem_data  = 24'd9;
        bus.elem_last  = 1'b1;
        start_list();
        c = 0;
        while (!DONE && c < 20) begin
            @(negedge clk);
            c++;
        end
        bus.elem_valid = 1'b0;
        checks++;
        if (c != 5) begin
            failures++;
            $display("FAIL single_done_latency: got %0d cycles, required 5", c);
        end
        checks++;
        if (LEN !== 7'd1 || mem[0] !== 24'd2 || mem[2] !== 24'd0 || mem[3] !== 24'd9) begin
            failures++;
            $display("FAIL single_contents: LEN=%0d w0=%0d w2=%0d w3=%0d, required 1 2 0 9",
                     LEN, mem[0], mem[2], mem[3]);
        end
        read_list(n, s);
        checks++;
        if (n != 1 || s != 64'd81) begin
            failures++;
            $display("FAIL single_reader: len=%0d sum=%0d, required len=1 sum=81", n, s);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int hs;
        int n;
        longint unsigned s;
        hs = 0;
        start_list();
        for (int i = 0; i < 130; i++) begin
            offer(24'(i + 1), 1'b0, 12, ok);
            if (ok) hs++;
        end
        bus.elem_valid = 1'b0;
        checks++;
        if (hs != 127) begin
            failures++;
            $display("FAIL ovf_handshakes: got %0d, required 127", hs);
        end
        checks++;
        if (LEN !== 7'd127 || DONE !== 1'b1 || OVF !== 1'b1 || bus.elem_ready !== 1'b0) begin
            failures++;
            $display("FAIL ovf_status: LEN=%0d DONE=%b OVF=%b rdy=%b, required 127 1 1 0",
                     LEN, DONE, OVF, bus.elem_ready);
        end
        checks++;
        if (mem[254] !== 24'd0 || mem[255] !== 24'd127 || mem[252] !== 24'd254) begin
            failures++;
            $display("FAIL ovf_tail: w252=%0d w254=%0d w255=%0d, required 254 0 127",
                     mem[252], mem[254], mem[255]);
        end
        read_list(n, s);
        checks++;
        if (n != 127) begin
            failures++;
            $display("FAIL ovf_reader_len: got %0d, required 127", n);
        end
    endtask

    task automatic test_restart_and_ignore();
        logic [32:0] exp_w [4] = '{{9'd0, 24'd0}, {9'd3, 24'd11}, {9'd2, 24'd0}, {9'd0, 24'd2}};
        bit ok;
        wlog.delete();
        start_list();
        checks++;
        if (DONE !== 1'b0 || OVF !== 1'b0 || LEN !== 7'd0 || bus.mem_we !== 1'b1 ||
            bus.mem_waddr !== 9'd0 || bus.mem_wdata !== 24'd0) begin
            failures++;
            $display("FAIL restart_clear: DONE=%b OVF=%b LEN=%0d we=%b addr=%0d data=%h, required 0 0 0 1 0 0",
                     DONE, OVF, LEN, bus.mem_we, bus.mem_waddr, bus.mem_wdata);
        end
        offer(24'd11, 1'b1, 20, ok);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        bus.elem_valid = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || LEN !== 7'd1 || OVF !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_status: DONE=%b LEN=%0d OVF=%b, required 1 1 0", DONE, LEN, OVF);
        end
        checks++;
        if (wlog.size() != 4) begin
            failures++;
            $display("FAIL ignore_start_writes: got %0d, required 4", wlog.size());
        end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL ignore_start_write%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         i, wlog[i][32:24], wlog[i][23:0], exp_w[i][32:24], exp_w[i][23:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n;
        longint unsigned s;
        start_list();
        offer(24'h123, 1'b0, 20, ok);
        bus.elem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 9'd2 || bus.mem_wdata !== 24'd0) begin
            failures++;
            $display("FAIL wterm_write: we=%b addr=%0d data=%h, required 1 2 0",
                     bus.mem_we, bus.mem_waddr, bus.mem_wdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({LEN, DONE, OVF, bus.elem_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== 44'd0) begin
            failures++;
            $display("FAIL async_reset: LEN=%0d DONE=%b OVF=%b rdy=%b we=%b addr=%0d data=%h, all required 0",
                     LEN, DONE, OVF, bus.elem_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_list();
        offer(24'hABC, 1'b1, 20, ok);
        bus.elem_valid = 1'b0;
        wait_done(ok);
        read_list(n, s);
        checks++;
        if (!ok || LEN !== 7'd1 || n != 1 || s != 64'hABC * 64'hABC) begin
            failures++;
            $display("FAIL post_reset_list: DONE=%b LEN=%0d len=%0d sum=%0d, required 1 1 1 %0d",
                     DONE, LEN, n, s, 64'hABC * 64'hABC);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        gap_writes = 0;
        for (int i = 0; i < 512; i++) mem[i] = 24'd0;
        test_reset();
        test_basic_list(0, "basic");
        test_single();
        test_basic_list(3, "gaps");
        test_overflow();
        test_restart_and_ignore();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
